// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - BRAM burst read port and decoder valid/ready bundle for inst_fetch_unit
interface inst_fetch_unit_if #(
    parameter int PC_W = 10
);
    logic [31:0]     fetch_addr;
    logic [31:0]     mem_w0;
    logic [31:0]     mem_w1;
    logic [31:0]     mem_w2;
    logic [31:0]     mem_w3;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst_data;
    logic [PC_W-1:0] inst_pc;

    modport master (
        output fetch_addr, inst_valid, inst_data, inst_pc,
        input  mem_w0, mem_w1, mem_w2, mem_w3, inst_ready
    );

    modport slave (
        input  fetch_addr, inst_valid, inst_data, inst_pc,
        output mem_w0, mem_w1, mem_w2, mem_w3, inst_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - 4-word burst instruction fetch into a queue with start/redirect/HALT
// Optional perf counters enabled by defining FETCH_PERF_EN.
module inst_fetch_unit #(
    parameter int          QDEPTH  = 8,
    parameter int          PC_W    = 10,
    parameter logic [31:0] HALT_OP = 32'hFFFFFFFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [PC_W-1:0]     start_pc,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    inst_fetch_unit_if.master   bus,
    output logic                busy,
    output logic                halted,
    output logic [31:0]         perf_stall,
    output logic [31:0]         perf_insts
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HALTED} state_t;

    state_t            state, state_nx;
    logic [PC_W-1:0]   pc;
    logic [PC_W-3:0]   grp_nx;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       q_data [QDEPTH];
    logic [PC_W-1:0]   q_pc   [QDEPTH];
    logic [31:0]       grp    [4];
    logic [3:0]        lane_en;
    logic [PTR_W-1:0]  lane_idx [4];
    logic [2:0]        n_push;
    logic              halt_seen;
    logic              do_fetch;
    logic              flush;
    logic              inst_valid;
    logic              pop;

    assign grp[0] = bus.mem_w0;
    assign grp[1] = bus.mem_w1;
    assign grp[2] = bus.mem_w2;
    assign grp[3] = bus.mem_w3;

    assign inst_valid     = (count != '0);
    assign pop            = inst_valid & bus.inst_ready;
    assign flush          = start | (redirect & ((state == S_FETCH) | (state == S_DRAIN)));
    // Free space is judged on the pre-pop count so a full burst always fits.
    assign do_fetch       = (state == S_FETCH) && !flush &&
                            ((CNT_W'(QDEPTH) - count) >= CNT_W'(4));
    assign grp_nx         = pc[PC_W-1:2] + (PC_W-2)'(1);

    assign bus.fetch_addr = 32'({pc[PC_W-1:2], 2'b00});
    assign bus.inst_valid = inst_valid;
    assign bus.inst_data  = inst_valid ? q_data[rd_ptr] : '0;
    assign bus.inst_pc    = inst_valid ? q_pc[rd_ptr]   : '0;
    assign busy           = (state == S_FETCH) || (state == S_DRAIN);
    assign halted         = (state == S_HALTED);

    // Lanes below pc[1:0] and lanes after a HALT are skipped; survivors pack contiguously.
    always_comb begin
        n_push    = '0;
        halt_seen = 1'b0;
        lane_en   = '0;
        for (int j = 0; j < 4; j++) begin
            lane_idx[j] = wr_ptr + PTR_W'(n_push);
            if (do_fetch && (2'(j) >= pc[1:0]) && !halt_seen) begin
                lane_en[j] = 1'b1;
                n_push     = n_push + 3'd1;
                halt_seen  = (grp[j] == HALT_OP);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (lane_en[j]) begin
                q_data[lane_idx[j]] <= grp[j];
                q_pc[lane_idx[j]]   <= {pc[PC_W-1:2], 2'(j)};
            end
        end
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = S_FETCH;
        end else if (flush) begin
            state_nx = S_FETCH;
        end else begin
            case (state)
                S_FETCH: if (do_fetch && halt_seen) state_nx = S_DRAIN;
                S_DRAIN: if (count == CNT_W'(pop)) state_nx = S_HALTED;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nx;
            if (flush) begin
                pc     <= start ? start_pc : redirect_pc;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_fetch) pc <= {grp_nx, 2'b00};
                wr_ptr <= wr_ptr + PTR_W'(n_push);
                rd_ptr <= rd_ptr + PTR_W'(pop);
                count  <= count + CNT_W'(n_push) - CNT_W'(pop);
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall <= '0;
            perf_insts <= '0;
        end else if (start) begin
            perf_stall <= '0;
            perf_insts <= '0;
        end else begin
            if (busy && !inst_valid && (perf_stall != 32'hFFFFFFFF))
                perf_stall <= perf_stall + 32'd1;
            if (pop && (perf_insts != 32'hFFFFFFFF))
                perf_insts <= perf_insts + 32'd1;
        end
    end
`else
    assign perf_stall = '0;
    assign perf_insts = '0;
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed-vector bench for inst_fetch_unit
module tb_inst_fetch_unit;
    localparam int          PC_W = 10;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            redirect = 1'b0;
    logic [PC_W-1:0] start_pc = '0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic            busy, halted;
    logic [31:0]     perf_stall, perf_insts;
    logic [31:0]     mem [1024];
    int              n_vec = 0;
    int              n_err = 0;

    inst_fetch_unit_if #(.PC_W(PC_W)) bus ();

    assign bus.mem_w0 = mem[bus.fetch_addr[9:0]];
    assign bus.mem_w1 = mem[bus.fetch_addr[9:0] | 10'd1];
    assign bus.mem_w2 = mem[bus.fetch_addr[9:0] | 10'd2];
    assign bus.mem_w3 = mem[bus.fetch_addr[9:0] | 10'd3];

    inst_fetch_unit #(.QDEPTH(8), .PC_W(PC_W), .HALT_OP(HALT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_pc    (start_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus),
        .busy        (busy),
        .halted      (halted),
        .perf_stall  (perf_stall),
        .perf_insts  (perf_insts)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [PC_W-1:0] pc);
        start = 1'b1;
        start_pc = pc;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        bus.inst_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if (bus.inst_valid !== 1'b0 || bus.inst_data !== 32'd0 || bus.inst_pc !== 10'd0 ||
            bus.fetch_addr !== 32'd0 || busy !== 1'b0 || halted !== 1'b0 ||
            perf_stall !== 32'd0 || perf_insts !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: valid=%0b data=%h pc=%0d faddr=%0d busy=%0b halted=%0b ps=%0d pi=%0d, want all 0",
                     bus.inst_valid, bus.inst_data, bus.inst_pc, bus.fetch_addr, busy, halted, perf_stall, perf_insts);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_halt_run();
        for (int i = 0; i < 8; i++) mem[i] = 32'h100 + i;
        mem[8] = HALT;
        for (int i = 9; i < 12; i++) mem[i] = 32'h999;
        bus.inst_ready = 1'b1;
        pulse_start(10'd0);
        n_vec++;
        if (bus.inst_valid !== 1'b0 || bus.fetch_addr !== 32'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL t1_first_cycle: valid=%0b faddr=%0d busy=%0b, want 0 0 1", bus.inst_valid, bus.fetch_addr, busy);
        end
        tick();
        for (int k = 0; k < 9; k++) begin
            n_vec++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 10'(k) ||
                bus.inst_data !== ((k == 8) ? HALT : 32'h100 + k) || halted !== 1'b0) begin
                n_err++;
                $display("FAIL t1_seq[%0d]: valid=%0b pc=%0d data=%h halted=%0b, want 1 %0d %h 0",
                         k, bus.inst_valid, bus.inst_pc, bus.inst_data, halted, k, (k == 8) ? HALT : 32'h100 + k);
            end
            tick();
        end
        n_vec++;
        if (halted !== 1'b1 || busy !== 1'b0 || bus.inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t1_halted: halted=%0b busy=%0b valid=%0b, want 1 0 0", halted, busy, bus.inst_valid);
        end
`ifdef FETCH_PERF_EN
        n_vec++;
        if (perf_stall !== 32'd1 || perf_insts !== 32'd9) begin
            n_err++;
            $display("FAIL t1_perf: stall=%0d insts=%0d, want 1 9", perf_stall, perf_insts);
        end
`else
        n_vec++;
        if (perf_stall !== 32'd0 || perf_insts !== 32'd0) begin
            n_err++;
            $display("FAIL t1_perf_off: stall=%0d insts=%0d, want 0 0", perf_stall, perf_insts);
        end
`endif
    endtask

    task automatic test_unaligned_start();
        bus.inst_ready = 1'b0;
        pulse_start(10'd5);
        n_vec++;
        if (bus.fetch_addr !== 32'd4 || bus.inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t2_first_addr: faddr=%0d valid=%0b, want 4 0", bus.fetch_addr, bus.inst_valid);
        end
        tick();
        n_vec++;
        if (bus.fetch_addr !== 32'd8) begin
            n_err++;
            $display("FAIL t2_next_addr: faddr=%0d, want 8", bus.fetch_addr);
        end
        bus.inst_ready = 1'b1;
        for (int k = 5; k < 9; k++) begin
            n_vec++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 10'(k) ||
                bus.inst_data !== ((k == 8) ? HALT : 32'h100 + k)) begin
                n_err++;
                $display("FAIL t2_seq[%0d]: valid=%0b pc=%0d data=%h, want 1 %0d", k, bus.inst_valid, bus.inst_pc, bus.inst_data, k);
            end
            tick();
        end
        n_vec++;
        if (halted !== 1'b1) begin
            n_err++;
            $display("FAIL t2_halted: halted=%0b, want 1", halted);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 16; i < 32; i++) mem[i] = 32'h200 + (i - 16);
        bus.inst_ready = 1'b0;
        pulse_start(10'd16);
        n_vec++;
        if (bus.fetch_addr !== 32'd16) begin
            n_err++;
            $display("FAIL t3_first_addr: faddr=%0d, want 16", bus.fetch_addr);
        end
        repeat (6) tick();
        n_vec++;
        if (bus.fetch_addr !== 32'd24 || bus.inst_valid !== 1'b1 || bus.inst_pc !== 10'd16 || bus.inst_data !== 32'h200) begin
            n_err++;
            $display("FAIL t3_full_hold: faddr=%0d valid=%0b pc=%0d data=%h, want 24 1 16 200",
                     bus.fetch_addr, bus.inst_valid, bus.inst_pc, bus.inst_data);
        end
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            n_vec++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 10'(16 + k) || bus.inst_data !== 32'h200 + k) begin
                n_err++;
                $display("FAIL t3_seq[%0d]: valid=%0b pc=%0d data=%h, want 1 %0d %h",
                         k, bus.inst_valid, bus.inst_pc, bus.inst_data, 16 + k, 32'h200 + k);
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        for (int i = 32; i < 48; i++) mem[i] = 32'h300 + (i - 32);
        bus.inst_ready = 1'b0;
        pulse_start(10'd18);
        repeat (4) tick();
        n_vec++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 10'd18 || bus.fetch_addr !== 32'd24) begin
            n_err++;
            $display("FAIL t4_pre: valid=%0b pc=%0d faddr=%0d, want 1 18 24", bus.inst_valid, bus.inst_pc, bus.fetch_addr);
        end
        redirect = 1'b1;
        redirect_pc = 10'h20;
        bus.inst_ready = 1'b1;
        tick();
        redirect = 1'b0;
        n_vec++;
        if (bus.inst_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL t4_flushed: valid=%0b busy=%0b, want 0 1", bus.inst_valid, busy);
        end
        tick();
        n_vec++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 10'h20 || bus.inst_data !== 32'h300) begin
            n_err++;
            $display("FAIL t4_target: valid=%0b pc=%0d data=%h, want 1 32 300", bus.inst_valid, bus.inst_pc, bus.inst_data);
        end
        tick();
        n_vec++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 10'h21 || bus.inst_data !== 32'h301) begin
            n_err++;
            $display("FAIL t4_next: valid=%0b pc=%0d data=%h, want 1 33 301", bus.inst_valid, bus.inst_pc, bus.inst_data);
        end
    endtask

    task automatic test_wrap();
        logic [PC_W-1:0] exp_pc;
        logic [31:0]     exp_data;
        for (int i = 1020; i < 1024; i++) mem[i] = 32'h400 + (i - 1020);
        for (int i = 0; i < 8; i++) mem[i] = 32'h100 + i;
        mem[8] = HALT;
        bus.inst_ready = 1'b1;
        pulse_start(10'd1020);
        n_vec++;
        if (bus.fetch_addr !== 32'd1020) begin
            n_err++;
            $display("FAIL t5_first_addr: faddr=%0d, want 1020", bus.fetch_addr);
        end
        tick();
        for (int k = 0; k < 13; k++) begin
            exp_pc = 10'(1020 + k);
            exp_data = (k < 4) ? 32'h400 + k : ((exp_pc == 10'd8) ? HALT : 32'h100 + 32'(exp_pc));
            n_vec++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc || bus.inst_data !== exp_data ||
                bus.fetch_addr > 32'd1020) begin
                n_err++;
                $display("FAIL t5_seq[%0d]: valid=%0b pc=%0d data=%h faddr=%0d, want 1 %0d %h <=1020",
                         k, bus.inst_valid, bus.inst_pc, bus.inst_data, bus.fetch_addr, exp_pc, exp_data);
            end
            tick();
        end
        n_vec++;
        if (halted !== 1'b1) begin
            n_err++;
            $display("FAIL t5_halted: halted=%0b, want 1", halted);
        end
    endtask

    task automatic test_async_reset();
        bus.inst_ready = 1'b0;
        pulse_start(10'd19);
        repeat (4) tick();
        n_vec++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 10'd19 || busy !== 1'b1 || bus.fetch_addr !== 32'd24) begin
            n_err++;
            $display("FAIL t6_pre: valid=%0b pc=%0d busy=%0b faddr=%0d, want 1 19 1 24",
                     bus.inst_valid, bus.inst_pc, busy, bus.fetch_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.inst_valid !== 1'b0 || bus.fetch_addr !== 32'd0 || busy !== 1'b0 || halted !== 1'b0 ||
            perf_stall !== 32'd0 || perf_insts !== 32'd0) begin
            n_err++;
            $display("FAIL t6_async: valid=%0b faddr=%0d busy=%0b halted=%0b ps=%0d pi=%0d, want all 0",
                     bus.inst_valid, bus.fetch_addr, busy, halted, perf_stall, perf_insts);
        end
        tick();
        rst_n = 1'b1;
        redirect = 1'b1;
        redirect_pc = 10'd5;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        n_vec++;
        if (busy !== 1'b0 || bus.inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t6_idle_redirect: busy=%0b valid=%0b, want 0 0", busy, bus.inst_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        bus.inst_ready = 1'b0;
        test_reset();
        test_halt_run();
        test_unaligned_start();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
